// File: rtl/move_input_conditioner_pkg.sv
// move_input_conditioner_pkg: direction codes, FSM states and priority pick shared with the game FSM.
package move_input_conditioner_pkg;
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    LOCKED  = 2'd2
  } state_t;
  function automatic logic [3:0] pick_dir(input logic [3:0] rise);
    return rise[3] ? DIR_UP : rise[2] ? DIR_DOWN : rise[1] ? DIR_LEFT : rise[0] ? DIR_RIGHT : DIR_NONE;
  endfunction
endpackage

// File: rtl/move_input_conditioner_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, counter debounce and rising-edge detect for one button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn,
  output logic s2,
  output logic stable,
  output logic rise
);
  logic s1, stable_d;
  logic [CNT_W-1:0] cnt;
  assign rise = stable & ~stable_d;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      stable_d <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      stable_d <= stable;
      if (s2 == stable) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/move_input_conditioner.sv
// move_input_conditioner: debounced one-move-per-press requests with release lockout for the game FSM.
module move_input_conditioner
  import move_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnL,
  input  logic BtnR,
  input  logic move_ready,
  output logic move_valid,
  output logic up,
  output logic down,
  output logic left,
  output logic right
);
  logic [3:0] raw, s2, stable, rise, dir;
  logic [CNT_W-1:0] release_cnt;
  logic released;
  state_t state;
  assign raw = {BtnU, BtnD, BtnL, BtnR};
  assign {up, down, left, right} = dir;
  assign released = ~|{stable, s2};
  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .Clk(Clk),
      .Reset(Reset),
      .btn(raw[g]),
      .s2(s2[g]),
      .stable(stable[g]),
      .rise(rise[g])
    );
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= LOCKED;
      move_valid <= 1'b0;
      dir <= DIR_NONE;
      release_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|rise) begin
          dir <= pick_dir(rise);
          move_valid <= 1'b1;
          state <= PENDING;
        end
        PENDING: if (move_ready) begin
          move_valid <= 1'b0;
          dir <= DIR_NONE;
          state <= LOCKED;
        end
        LOCKED: begin
          // re-arm only after every button has been fully quiet long enough
          if (!released) release_cnt <= '0;
          else if (release_cnt == CNT_W'(DEBOUNCE_CYCLES + 2)) begin
            release_cnt <= '0;
            state <= IDLE;
          end else release_cnt <= release_cnt + 1'b1;
        end
        default: state <= LOCKED;
      endcase
    end
  end
endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner: directed scenarios plus random traffic checked against a history-window reference model.
module tb_move_input_conditioner;
  localparam int DEB = 4;
  logic Clk, Reset, BtnU, BtnD, BtnL, BtnR, move_ready;
  logic move_valid, up, down, left, right;
  int checks = 0, errors = 0;
  int acc = 0, mvc = 0;
  logic [3:0] last_dir = 4'b0;
  logic [DEB:0] h [4];
  logic [3:0] m_stab, m_stab_d, m_dir;
  logic m_mv;
  int st, rel;

  move_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .move_ready(move_ready), .move_valid(move_valid), .up(up), .down(down), .left(left), .right(right)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [3:0] b, input logic r, input logic rs);
    logic [3:0] rise, s2v, nxt;
    logic same;
    rise = m_stab & ~m_stab_d;
    nxt = m_stab;
    for (int i = 0; i < 4; i++) begin
      s2v[i] = h[i][1];
      same = 1'b1;
      for (int j = 1; j <= DEB; j++) if (h[i][j] !== h[i][1]) same = 1'b0;
      if (same && h[i][1] !== m_stab[i]) nxt[i] = h[i][1];
    end
    if (rs) begin
      for (int i = 0; i < 4; i++) h[i] = '0;
      m_stab = 4'b0; m_stab_d = 4'b0; m_dir = 4'b0; m_mv = 1'b0; st = 2; rel = 0;
    end else begin
      if (st == 0) begin
        if (|rise) begin
          m_dir = 4'b0;
          for (int i = 0; i < 4; i++) if (rise[i]) m_dir = 4'b1 << i;
          m_mv = 1'b1; st = 1;
        end
      end else if (st == 1) begin
        if (r) begin m_mv = 1'b0; m_dir = 4'b0; st = 2; end
      end else begin
        if (|m_stab || |s2v) rel = 0;
        else if (rel == DEB + 2) begin rel = 0; st = 0; end
        else rel++;
      end
      m_stab_d = m_stab;
      m_stab = nxt;
      for (int i = 0; i < 4; i++) h[i] = {h[i][DEB-1:0], b[i]};
    end
  endtask

  task automatic step(input logic [3:0] b, input logic r, input logic rs);
    {BtnU, BtnD, BtnL, BtnR} = b;
    move_ready = r;
    Reset = rs;
    if (move_valid && r && !rs) begin
      acc++;
      last_dir = {up, down, left, right};
    end
    @(posedge Clk);
    model(b, r, rs);
    #1;
    chk("move_valid", int'(move_valid), int'(m_mv));
    chk("direction", int'({up, down, left, right}), int'(m_dir));
    if (move_valid) mvc++;
  endtask

  task automatic run(input logic [3:0] b, input logic r, input int n);
    for (int k = 0; k < n; k++) step(b, r, 1'b0);
  endtask

  task automatic wait_mv(input logic [3:0] b, input logic r, input string tag);
    int k;
    k = 0;
    while (!move_valid && k < 20) begin step(b, r, 1'b0); k++; end
    chk(tag, int'(move_valid), 1);
  endtask

  initial begin
    int a0, first;
    logic [3:0] cur;
    for (int i = 0; i < 4; i++) h[i] = '0;
    m_stab = 4'b0; m_stab_d = 4'b0; m_dir = 4'b0; m_mv = 1'b0; st = 2; rel = 0;
    {BtnU, BtnD, BtnL, BtnR} = 4'b0; move_ready = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 3; k++) step(4'b0, 1'b0, 1'b1);
    chk("reset_valid", int'(move_valid), 0);
    chk("reset_dir", int'({up, down, left, right}), 0);
    run(4'b0, 1'b1, 10);
    // single up press: valid appears after edge 7 and lasts one cycle
    a0 = acc; mvc = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      step(4'b1000, 1'b1, 1'b0);
      if (move_valid && first == 0) first = k;
    end
    chk("up_latency", first, 7);
    chk("up_valid_cycles", mvc, 1);
    chk("up_moves", acc - a0, 1);
    chk("up_dir", int'(last_dir), 4'b1000);
    run(4'b0, 1'b1, 15);
    // bouncing down button never debounces
    a0 = acc;
    for (int k = 0; k < 20; k++) step((k % 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
    run(4'b0, 1'b1, 15);
    chk("bounce_moves", acc - a0, 0);
    // simultaneous left+right: left wins, right discarded
    a0 = acc;
    run(4'b0011, 1'b1, 12);
    chk("lr_moves", acc - a0, 1);
    chk("lr_dir", int'(last_dir), 4'b0010);
    run(4'b0, 1'b1, 15);
    run(4'b0001, 1'b1, 12);
    chk("r_moves", acc - a0, 2);
    chk("r_dir", int'(last_dir), 4'b0001);
    run(4'b0, 1'b1, 15);
    // held request while not ready; later up press ignored
    a0 = acc;
    wait_mv(4'b0100, 1'b0, "down_pending");
    run(4'b1100, 1'b0, 10);
    chk("hold_valid", int'(move_valid), 1);
    chk("hold_dir", int'({up, down, left, right}), 4'b0100);
    step(4'b1100, 1'b1, 1'b0);
    chk("accept_drop", int'(move_valid), 0);
    run(4'b0100, 1'b1, 50);
    chk("no_repeat", acc - a0, 1);
    chk("down_dir", int'(last_dir), 4'b0100);
    run(4'b0, 1'b1, 15);
    // reset mid-pending loses the move
    a0 = acc;
    wait_mv(4'b0010, 1'b0, "left_pending");
    step(4'b0010, 1'b1, 1'b1);
    chk("reset_drop", int'(move_valid), 0);
    run(4'b0010, 1'b1, 20);
    chk("reset_lost", acc - a0, 0);
    run(4'b0, 1'b1, 15);
    // right held through reset cannot fire until released and re-pressed
    a0 = acc;
    run(4'b0001, 1'b1, 3);
    for (int k = 0; k < 3; k++) step(4'b0001, 1'b1, 1'b1);
    run(4'b0001, 1'b1, 30);
    chk("held_reset", acc - a0, 0);
    run(4'b0, 1'b1, 15);
    run(4'b0001, 1'b1, 12);
    chk("held_repress", acc - a0, 1);
    chk("held_dir", int'(last_dir), 4'b0001);
    run(4'b0, 1'b1, 15);
    // short release with glitch keeps the lockout
    a0 = acc;
    run(4'b1000, 1'b1, 12);
    run(4'b0, 1'b1, 3);
    run(4'b1000, 1'b1, 2);
    run(4'b0, 1'b1, 3);
    run(4'b1000, 1'b1, 12);
    chk("glitch_locked", acc - a0, 1);
    run(4'b0, 1'b1, 15);
    run(4'b1000, 1'b1, 12);
    chk("second_move", acc - a0, 2);
    run(4'b0, 1'b1, 15);
    // random traffic against the model
    cur = 4'b0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
      step(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
